// File: rtl/tmp_pkg.sv
// Shared types and default constants for the TMP sensor SPI reader.
package tmp_pkg;

  localparam int unsigned TMP_CLK_DIV_DEF    = 4;
  localparam int unsigned TMP_FRAME_BITS_DEF = 16;
  localparam int unsigned TMP_BYTE_LSB_DEF   = 7;
  localparam int unsigned TMP_BYTE_W         = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_DONE
  } tmp_spi_state_t;

endpackage

// File: rtl/tmp_clk_div.sv
// Tick generator: counts 0..DIV-1 while enabled and pulses tick_c on the wrap cycle.
module tmp_clk_div import tmp_pkg::*; #(
  parameter int unsigned DIV = TMP_CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned     CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick_c = en && !clr && (cnt == LAST);

endmodule

// File: rtl/tmp_spi_reader.sv
// SPI mode-0 master: reads one sensor frame and writes the extracted byte to the data register.
// Build option TMP_AUTO_SAMPLE_EN adds a periodic auto-start counter (AUTO_PERIOD clocks).
module tmp_spi_reader import tmp_pkg::*; #(
  parameter int unsigned CLK_DIV    = TMP_CLK_DIV_DEF,
  parameter int unsigned FRAME_BITS = TMP_FRAME_BITS_DEF,
  parameter int unsigned BYTE_LSB   = TMP_BYTE_LSB_DEF
`ifdef TMP_AUTO_SAMPLE_EN
  ,
  parameter int unsigned AUTO_PERIOD = 1000000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  spi_miso,
  output logic                  spi_sclk,
  output logic                  spi_cs_n,
  output logic                  busy,
  output logic                  wr_1,
  output logic [TMP_BYTE_W-1:0] data_out
);

  localparam int unsigned      TGL_W    = $clog2(2 * FRAME_BITS);
  localparam logic [TGL_W-1:0] TGL_LAST = TGL_W'(2 * FRAME_BITS - 1);

  tmp_spi_state_t        state, state_n;
  logic                  sclk_n, cs_n_n, wr_n;
  logic [TMP_BYTE_W-1:0] data_n;
  logic [TGL_W-1:0]      tgl, tgl_n;
  logic                  tick_c, start_c, rise_c;
  logic                  miso_s1, miso_s2;
  logic [1:0]            rise_d;
  logic [FRAME_BITS-1:0] shreg;

  tmp_clk_div #(
    .DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .en     (state != ST_IDLE),
    .clr    (state == ST_IDLE),
    .tick_c (tick_c)
  );

`ifdef TMP_AUTO_SAMPLE_EN
  localparam int unsigned       AUTO_W    = $clog2(AUTO_PERIOD) + 1;
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] auto_cnt;
  logic              auto_due_c;

  // Free-running period counter; reloads on reset and on every DONE, saturates when due.
  always_ff @(posedge clk) begin
    if (!rst || state == ST_DONE) begin
      auto_cnt <= '0;
    end else if (!auto_due_c) begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  assign auto_due_c = (auto_cnt == AUTO_LAST);
  assign start_c    = start || auto_due_c;
`else
  assign start_c = start;
`endif

  assign rise_c = (state == ST_SHIFT) && tick_c && !spi_sclk;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      spi_sclk <= 1'b0;
      spi_cs_n <= 1'b1;
      busy     <= 1'b0;
      wr_1     <= 1'b0;
      data_out <= '0;
      tgl      <= '0;
    end else begin
      state    <= state_n;
      spi_sclk <= sclk_n;
      spi_cs_n <= cs_n_n;
      busy     <= (state_n != ST_IDLE);
      wr_1     <= wr_n;
      data_out <= data_n;
      tgl      <= tgl_n;
    end
  end

  always_comb begin
    state_n = state;
    sclk_n  = spi_sclk;
    cs_n_n  = spi_cs_n;
    wr_n    = 1'b0;
    data_n  = data_out;
    tgl_n   = tgl;
    unique case (state)
      ST_IDLE: begin
        sclk_n = 1'b0;
        cs_n_n = 1'b1;
        if (start_c) begin
          state_n = ST_CS_SETUP;
          cs_n_n  = 1'b0;
          tgl_n   = '0;
        end
      end
      ST_CS_SETUP: begin
        if (tick_c) begin
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (tick_c) begin
          sclk_n = !spi_sclk;
          tgl_n  = tgl + 1'b1;
          if (tgl == TGL_LAST) begin
            state_n = ST_CS_HOLD;
            sclk_n  = 1'b0;
          end
        end
      end
      ST_CS_HOLD: begin
        // Byte goes out together with the strobe as DONE is entered.
        if (tick_c) begin
          state_n = ST_DONE;
          cs_n_n  = 1'b1;
          wr_n    = 1'b1;
          data_n  = shreg[BYTE_LSB +: TMP_BYTE_W];
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // MISO is synchronized, so each bit is captured two clocks after its rising SCLK edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      miso_s1 <= 1'b0;
      miso_s2 <= 1'b0;
      rise_d  <= '0;
      shreg   <= '0;
    end else begin
      miso_s1 <= spi_miso;
      miso_s2 <= miso_s1;
      rise_d  <= {rise_d[0], rise_c};
      if (rise_d[1]) begin
        shreg <= FRAME_BITS'({shreg, miso_s2});
      end
    end
  end

endmodule

// File: tb/tb_tmp_spi_reader.sv
// Scoreboard bench for tmp_spi_reader: sensor model, reference timing model and decoupled monitor.
`timescale 1ns/1ps
module tb_tmp_spi_reader;

  localparam int unsigned CLK_DIV    = 2;
  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned BYTE_LSB   = 7;
  localparam int unsigned LAT        = CLK_DIV * (2 * FRAME_BITS + 2);

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       spi_miso = 1'b0;
  logic       spi_sclk, spi_cs_n, busy, wr_1;
  logic [7:0] data_out;

  tmp_spi_reader #(
    .CLK_DIV    (CLK_DIV),
    .FRAME_BITS (FRAME_BITS),
    .BYTE_LSB   (BYTE_LSB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .spi_miso (spi_miso),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .busy     (busy),
    .wr_1     (wr_1),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [7:0]  val;
  } exp_t;

  exp_t                  sb[$];
  int                    checks = 0;
  int                    errors = 0;
  int unsigned           cyc = 0;
  int unsigned           idle_at = 0;
  logic                  win_valid = 1'b0;
  int unsigned           win_lo = 0;
  int unsigned           win_hi = 0;
  logic [7:0]            held = 8'h00;
  int unsigned           rises = 0;
  logic [FRAME_BITS-1:0] cur_frame = '0;
  logic [FRAME_BITS-1:0] sens_frame = '0;
  int                    sens_idx = 0;
  logic                  exp_busy, exp_cs_low;
  exp_t                  e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Sensor: presents MSB when selected, shifts out the next bit after each falling SCLK.
  always @(negedge spi_cs_n) begin
    sens_frame = cur_frame;
    sens_idx   = FRAME_BITS - 1;
    #1 spi_miso = sens_frame[sens_idx];
  end

  always @(negedge spi_sclk) begin
    if (spi_cs_n === 1'b0) begin
      sens_idx--;
      if (sens_idx >= 0) #1 spi_miso = sens_frame[sens_idx];
    end
  end

  always @(posedge spi_sclk) begin
    if (spi_cs_n === 1'b0) rises++;
  end

  // Reference model: acceptance, latency window and expected byte.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      sb.delete();
      win_valid = 1'b0;
      held      = 8'h00;
      idle_at   = cyc + 1;
    end else if (start && cyc >= idle_at) begin
      sb.push_back('{due: cyc + LAT, val: 8'(cur_frame >> BYTE_LSB)});
      win_valid = 1'b1;
      win_lo    = cyc;
      win_hi    = cyc + LAT;
      idle_at   = cyc + LAT + 2;
      rises     = 0;
    end
  end

  // Monitor: compares DUT outputs against the model every cycle.
  always @(negedge clk) begin
    exp_busy   = win_valid && cyc >= win_lo && cyc <= win_hi;
    exp_cs_low = win_valid && cyc >= win_lo && cyc < win_hi;
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("cs_n", 32'(spi_cs_n), 32'(!exp_cs_low));
    if (!exp_cs_low) chk("sclk_idle", 32'(spi_sclk), 32'd0);
    if (sb.size() > 0 && cyc > sb[0].due) begin
      checks++;
      errors++;
      $display("FAIL missing_wr actual=none expected_cyc=%0d cyc=%0d", sb[0].due, cyc);
      void'(sb.pop_front());
    end
    if (wr_1 === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_wr actual=1 expected=0 cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("wr_latency", cyc, e.due);
        chk("data_out", 32'(data_out), 32'(e.val));
        chk("sclk_rises", rises, FRAME_BITS);
        held = e.val;
      end
    end else begin
      chk("data_hold", 32'(data_out), 32'(held));
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || cyc + 1 < idle_at) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle actual=timeout expected=idle cyc=%0d", cyc);
    end
  endtask

  task automatic wait_rises(input int unsigned target);
    int n = 0;
    while (rises < target && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL wait_rises actual=%0d expected=%0d", rises, target);
    end
  endtask

  task automatic convert(input logic [FRAME_BITS-1:0] frame, input int unsigned hold);
    wait_idle();
    cur_frame = frame;
    start     = 1'b1;
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b1;
    repeat (5) @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);

    convert(16'h0C80, 1);
    convert(16'h7F80, 1);
    convert(16'h807F, 1);

    // Start pulses while busy must be ignored.
    convert(16'hA5C3, 1);
    wait_rises(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_rises(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Reset mid-frame discards the partial frame.
    convert(16'h3C3C, 1);
    wait_rises(8);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    convert(16'h1400, 1);

    // Start held high re-triggers after DONE.
    convert(16'h2A80, LAT + 6);

    for (int i = 0; i < 20; i++) begin
      convert(16'($urandom), $urandom_range(1, 3));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(4, 40)) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_idle();
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    wait_idle();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
